ray_result_collector: RTL and testbench

Downstream stage of the ray-tracer core. Captures each single-cycle `ray_done` result, tags it with a sequential pixel index, and buffers it in a small FIFO. The FIFO is drained through a valid/ready stream toward the framebuffer writer. The core's result port has no backpressure, so the block also throttles new job issue via `job_gate`, guaranteeing FIFO space for every in-flight ray. It also keeps per-frame status: pixel counter, hit count, sticky overflow, and a frame-done pulse.

---
 rtl/ray_result_collector.sv | 173 +++++++++++++++++
 tb/tb_ray_result_collector.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_result_collector.sv
// Purpose: tag each ray result with a pixel index, buffer it in a small FIFO, gate job issue, keep frame status.
// Latency: ray_done at edge N -> res_valid high from cycle N+1 when the FIFO was empty (show-ahead head).
// Backpressure: res_ready stalls the stream; the core cannot be stalled, so job_gate reserves space for rays in flight.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   job_fire / job_gate           job accepted by the core / permission to present a new job
//   ray_done, ray_hit, ray_timeout,
//   hit_voxel_x/y/z, hit_face_id,
//   steps_taken                   single-cycle result from the core
//   frame_start                   clears pixel counter, hit count and overflow
//   res_valid/res_ready, res_*    result stream toward the framebuffer writer
//   fifo_count, hit_count,
//   overflow, frame_done          status
module ray_result_collector #(
  parameter int COORD_WIDTH      = 16,
  parameter int STEP_COUNT_WIDTH = 16,
  parameter int PIX_BITS         = 10,
  parameter int FRAME_PIXELS     = 1024,
  parameter int FIFO_DEPTH       = 8,
  parameter int CNT_BITS         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        job_fire,
  output logic                        job_gate,
  input  logic                        ray_done,
  input  logic                        ray_hit,
  input  logic                        ray_timeout,
  input  logic [COORD_WIDTH-1:0]      hit_voxel_x,
  input  logic [COORD_WIDTH-1:0]      hit_voxel_y,
  input  logic [COORD_WIDTH-1:0]      hit_voxel_z,
  input  logic [2:0]                  hit_face_id,
  input  logic [STEP_COUNT_WIDTH-1:0] steps_taken,
  input  logic                        frame_start,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [PIX_BITS-1:0]         res_pixel,
  output logic                        res_hit,
  output logic                        res_timeout,
  output logic [COORD_WIDTH-1:0]      res_x,
  output logic [COORD_WIDTH-1:0]      res_y,
  output logic [COORD_WIDTH-1:0]      res_z,
  output logic [2:0]                  res_face,
  output logic [STEP_COUNT_WIDTH-1:0] res_steps,
  output logic [CNT_BITS-1:0]         fifo_count,
  output logic [PIX_BITS:0]           hit_count,
  output logic                        overflow,
  output logic                        frame_done
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam logic [PIX_BITS-1:0] LAST_PIX = PIX_BITS'(FRAME_PIXELS - 1);
  localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(FIFO_DEPTH);
  localparam logic [CNT_BITS:0]   DEPTH_EXT = (CNT_BITS + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [PIX_BITS-1:0]         pix;
    logic                        hit;
    logic                        timeout;
    logic [COORD_WIDTH-1:0]      x;
    logic [COORD_WIDTH-1:0]      y;
    logic [COORD_WIDTH-1:0]      z;
    logic [2:0]                  face;
    logic [STEP_COUNT_WIDTH-1:0] steps;
  } entry_t;

  entry_t              mem_q [FIFO_DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d, inflight_q, inflight_d;
  logic [PIX_BITS-1:0] pix_cnt_q, pix_cnt_d;
  logic [PIX_BITS:0]   hit_cnt_q, hit_cnt_d, hit_base;
  logic                overflow_q, overflow_d, frame_done_q, frame_done_d;
  logic                full, push, pop, drop, wrap, head_vld;
  logic [PIX_BITS-1:0] tag;
  entry_t              wr_entry, head;

  always_comb begin
    head_vld = (count_q != '0);
    full     = (count_q == DEPTH_CNT);
    pop      = head_vld & res_ready;
    // A full FIFO still accepts a result if the head leaves on the same edge.
    push     = ray_done & (~full | pop);
    drop     = ray_done & full & ~pop;

    // frame_start restarts tagging on this very result.
    tag  = frame_start ? '0 : pix_cnt_q;
    wrap = ray_done & (tag == LAST_PIX);

    wr_entry         = '0;
    wr_entry.pix     = tag;
    wr_entry.hit     = ray_hit;
    wr_entry.timeout = ray_timeout;
    wr_entry.x       = hit_voxel_x;
    wr_entry.y       = hit_voxel_y;
    wr_entry.z       = hit_voxel_z;
    wr_entry.face    = hit_face_id;
    wr_entry.steps   = steps_taken;

    wr_ptr_d = push ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_BITS'(1) : rd_ptr_q;
    count_d  = count_q + CNT_BITS'(push) - CNT_BITS'(pop);

    // In-flight never goes below zero: stray results are still captured.
    inflight_d = inflight_q;
    if (job_fire && !ray_done && inflight_q != '1)
      inflight_d = inflight_q + CNT_BITS'(1);
    else if (!job_fire && ray_done && inflight_q != '0)
      inflight_d = inflight_q - CNT_BITS'(1);

    // Dropped results still advance the tag so pixels stay aligned with ray order.
    pix_cnt_d = frame_start ? '0 : pix_cnt_q;
    if (ray_done)
      pix_cnt_d = wrap ? '0 : tag + PIX_BITS'(1);

    hit_base  = frame_start ? '0 : hit_cnt_q;
    hit_cnt_d = hit_base;
    if (ray_done && ray_hit && hit_base != '1)
      hit_cnt_d = hit_base + (PIX_BITS + 1)'(1);

    overflow_d   = (overflow_q & ~frame_start) | drop;
    frame_done_d = wrap & ~frame_start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= '0;
      pix_cnt_q    <= '0;
      hit_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      pix_cnt_q    <= pix_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Storage needs no reset; the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push)
      mem_q[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    head = head_vld ? mem_q[rd_ptr_q] : '0;
  end

  assign res_valid   = head_vld;
  assign res_pixel   = head.pix;
  assign res_hit     = head.hit;
  assign res_timeout = head.timeout;
  assign res_x       = head.x;
  assign res_y       = head.y;
  assign res_z       = head.z;
  assign res_face    = head.face;
  assign res_steps   = head.steps;
  assign fifo_count  = count_q;
  assign hit_count   = hit_cnt_q;
  assign overflow    = overflow_q;
  assign frame_done  = frame_done_q;
  // Sum in one extra bit so a full FIFO plus in-flight rays cannot wrap.
  assign job_gate    = ({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_EXT;

endmodule

// File: tb/tb_ray_result_collector.sv
// Purpose: scoreboard bench for ray_result_collector; two instances (1024- and 4-pixel frames) share one stimulus.
// Latency: expected entries are queued on the capture edge and checked when the head is accepted.
// Backpressure: res_ready is driven directly by the directed scenarios.
module tb_ray_result_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_fire = 1'b0, ray_done = 1'b0, ray_hit = 1'b0, ray_timeout = 1'b0;
  logic [15:0] hx = '0, hy = '0, hz = '0, hsteps = '0;
  logic [2:0]  hface = '0;
  logic        frame_start = 1'b0, res_ready = 1'b0;

  logic        a_gate, a_valid, a_hit, a_to, a_ovf, a_fd;
  logic [9:0]  a_pix;
  logic [15:0] a_x, a_y, a_z, a_steps;
  logic [2:0]  a_face;
  logic [3:0]  a_cnt;
  logic [10:0] a_hits;

  logic        b_gate, b_valid, b_hit, b_to, b_ovf, b_fd;
  logic [9:0]  b_pix;
  logic [15:0] b_x, b_y, b_z, b_steps;
  logic [2:0]  b_face;
  logic [3:0]  b_cnt;
  logic [10:0] b_hits;

  int n_cmp = 0;
  int n_bad = 0;
  int pix_a = 0;
  int pix_b = 0;
  logic [78:0] qa[$];
  logic [78:0] qb[$];

  always #5 clk = ~clk;

  ray_result_collector dut_a (
    .clk(clk), .rst(rst), .job_fire(job_fire), .job_gate(a_gate),
    .ray_done(ray_done), .ray_hit(ray_hit), .ray_timeout(ray_timeout),
    .hit_voxel_x(hx), .hit_voxel_y(hy), .hit_voxel_z(hz), .hit_face_id(hface),
    .steps_taken(hsteps), .frame_start(frame_start),
    .res_valid(a_valid), .res_ready(res_ready), .res_pixel(a_pix), .res_hit(a_hit),
    .res_timeout(a_to), .res_x(a_x), .res_y(a_y), .res_z(a_z), .res_face(a_face),
    .res_steps(a_steps), .fifo_count(a_cnt), .hit_count(a_hits), .overflow(a_ovf),
    .frame_done(a_fd)
  );

  ray_result_collector #(.FRAME_PIXELS(4)) dut_b (
    .clk(clk), .rst(rst), .job_fire(job_fire), .job_gate(b_gate),
    .ray_done(ray_done), .ray_hit(ray_hit), .ray_timeout(ray_timeout),
    .hit_voxel_x(hx), .hit_voxel_y(hy), .hit_voxel_z(hz), .hit_face_id(hface),
    .steps_taken(hsteps), .frame_start(frame_start),
    .res_valid(b_valid), .res_ready(res_ready), .res_pixel(b_pix), .res_hit(b_hit),
    .res_timeout(b_to), .res_x(b_x), .res_y(b_y), .res_z(b_z), .res_face(b_face),
    .res_steps(b_steps), .fifo_count(b_cnt), .hit_count(b_hits), .overflow(b_ovf),
    .frame_done(b_fd)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: whenever a head is accepted, it must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && res_ready && a_valid) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_a: popped pixel %0d, expected nothing", a_pix);
      end else
        check("sb_a", {a_pix, a_hit, a_to, a_x, a_y, a_z, a_face, a_steps}, qa.pop_front());
    end
    if (!rst && res_ready && b_valid) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_b: popped pixel %0d, expected nothing", b_pix);
      end else
        check("sb_b", {b_pix, b_hit, b_to, b_x, b_y, b_z, b_face, b_steps}, qb.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send_ray(input logic fs, input logic hit, input logic to,
                          input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                          input logic [2:0] face, input logic [15:0] steps, input logic drop);
    int ta, tb;
    frame_start = fs; ray_done = 1'b1; ray_hit = hit; ray_timeout = to;
    hx = x; hy = y; hz = z; hface = face; hsteps = steps;
    cyc();
    ta = fs ? 0 : pix_a;
    tb = fs ? 0 : pix_b;
    if (!drop) begin
      qa.push_back({10'(ta), hit, to, x, y, z, face, steps});
      qb.push_back({10'(tb), hit, to, x, y, z, face, steps});
    end
    pix_a = (ta + 1) % 1024;
    pix_b = (tb + 1) % 4;
    ray_done = 1'b0; frame_start = 1'b0;
  endtask

  task automatic do_reset(input logic with_ray);
    rst = 1'b1; ray_done = with_ray;
    cyc();
    rst = 1'b0; ray_done = 1'b0;
    qa.delete(); qb.delete();
    pix_a = 0; pix_b = 0;
  endtask

  initial begin
    // Reset state
    do_reset(1'b0);
    do_reset(1'b0);
    @(negedge clk);
    check("rst_valid", a_valid, 1'b0);
    check("rst_count", a_cnt, 4'd0);
    check("rst_gate", a_gate, 1'b1);
    check("rst_gate_b", b_gate, 1'b1);
    check("rst_ovf", a_ovf, 1'b0);
    check("rst_fd", a_fd, 1'b0);
    check("rst_hits", a_hits, 11'd0);
    check("rst_data", {a_pix, a_x, a_steps}, 42'd0);

    // Single ray
    job_fire = 1'b1; cyc(); job_fire = 1'b0;
    @(negedge clk);
    check("one_gate", a_gate, 1'b1);
    repeat (4) cyc();
    send_ray(1'b0, 1'b1, 1'b0, 16'd3, 16'd7, 16'd12, 3'd2, 16'd9, 1'b0);
    @(negedge clk);
    check("one_valid", a_valid, 1'b1);
    check("one_pixel", a_pix, 10'd0);
    check("one_fields", {a_x, a_y, a_z, a_face, a_steps}, {16'd3, 16'd7, 16'd12, 3'd2, 16'd9});
    check("one_hits", a_hits, 11'd1);
    check("one_count", a_cnt, 4'd1);
    cyc(); res_ready = 1'b1; cyc(); res_ready = 1'b0;
    @(negedge clk);
    check("one_drained", a_valid, 1'b0);

    // Gate fill: 8 fire/done pairs, nothing drained
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      job_fire = 1'b1; cyc(); job_fire = 1'b0;
      if (i == 7) begin
        @(negedge clk);
        check("gate_7_inflight", a_gate, 1'b0);
      end
      send_ray(1'b0, 1'(i % 2), 1'(i % 3 == 0), 16'(i * 5 + 1), 16'(100 + i),
               16'(i * i), 3'(i), 16'(i * 7 + 2), 1'b0);
      @(negedge clk);
      if (i == 6) check("gate_7_idle", a_gate, 1'b1);
    end
    check("fill_count", a_cnt, 4'd8);
    check("fill_gate", a_gate, 1'b0);
    check("fill_ovf", a_ovf, 1'b0);

    // Full push+pop: head (pixel 0) leaves while pixel 8 enters
    cyc(); res_ready = 1'b1;
    send_ray(1'b0, 1'b1, 1'b0, 16'hAAAA, 16'h5555, 16'h0F0F, 3'd5, 16'd77, 1'b0);
    res_ready = 1'b0;
    @(negedge clk);
    check("pp_count", a_cnt, 4'd8);
    check("pp_ovf", a_ovf, 1'b0);

    // Forced overflow: pixel 9 dropped, still counted
    send_ray(1'b0, 1'b1, 1'b1, 16'hDEAD, 16'hBEEF, 16'h1234, 3'd1, 16'd3, 1'b1);
    @(negedge clk);
    check("ovf_set", a_ovf, 1'b1);
    check("ovf_count", a_cnt, 4'd8);
    check("ovf_hits", a_hits, 11'd6);
    check("ovf_gate", a_gate, 1'b0);

    // Drain: the push+pop entry reaches the head after 7 more pops
    cyc(); res_ready = 1'b1;
    repeat (7) cyc();
    @(negedge clk);
    check("pp_head_pixel", a_pix, 10'd8);
    check("pp_head_x", a_x, 16'hAAAA);
    cyc(); res_ready = 1'b0;
    @(negedge clk);
    check("drain_valid", a_valid, 1'b0);
    check("drain_gate", a_gate, 1'b1);

    send_ray(1'b0, 1'b0, 1'b0, 16'd42, 16'd43, 16'd44, 3'd6, 16'd45, 1'b0);
    @(negedge clk);
    check("after_drop_pixel", a_pix, 10'd10);
    cyc(); res_ready = 1'b1; cyc(); res_ready = 1'b0;

    // Frame wrap on the 4-pixel instance
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    pix_a = 0; pix_b = 0;
    @(negedge clk);
    check("fs_ovf_clr", a_ovf, 1'b0);
    check("fs_hits_clr", a_hits, 11'd0);
    cyc(); res_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      send_ray(1'b0, 1'(k == 1 || k == 4), 1'b0, 16'(k), 16'(k + 20), 16'(k + 40),
               3'(k), 16'(k + 60), 1'b0);
      @(negedge clk);
      check($sformatf("frame_done_%0d", k), b_fd, 1'(k == 3));
    end
    check("frame_hits", a_hits, 11'd2);
    send_ray(1'b1, 1'b1, 1'b0, 16'd9, 16'd9, 16'd9, 3'd3, 16'd9, 1'b0);
    @(negedge clk);
    check("fs_ray_fd", b_fd, 1'b0);
    check("fs_ray_hits", a_hits, 11'd1);
    check("fs_ray_ovf", b_ovf, 1'b0);
    repeat (2) cyc();
    res_ready = 1'b0;

    // Reset mid-stream with a ray in the reset cycle
    for (int k = 0; k < 3; k++)
      send_ray(1'b0, 1'b1, 1'b0, 16'(k + 1), 16'd0, 16'd0, 3'd0, 16'd1, 1'b0);
    job_fire = 1'b1; cyc(); job_fire = 1'b0;
    @(negedge clk);
    check("mid_count", a_cnt, 4'd3);
    do_reset(1'b1);
    @(negedge clk);
    check("mid_rst_valid", a_valid, 1'b0);
    check("mid_rst_count", a_cnt, 4'd0);
    check("mid_rst_gate", a_gate, 1'b1);
    check("mid_rst_hits", a_hits, 11'd0);
    send_ray(1'b0, 1'b1, 1'b0, 16'd5, 16'd6, 16'd7, 3'd4, 16'd8, 1'b0);
    @(negedge clk);
    check("post_rst_count", a_cnt, 4'd1);
    check("post_rst_pixel", a_pix, 10'd0);
    cyc(); res_ready = 1'b1; cyc(); res_ready = 1'b0;
    @(negedge clk);
    check("sb_a_empty", 32'(qa.size()), 32'd0);
    check("sb_b_empty", 32'(qb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
